// File: rtl/mul_div_exec_unit_pkg.sv
// Shared types and constants for the RV32M multiply/divide execution unit:
// opcode and FSM encodings plus small datapath helpers.
package mul_div_exec_unit_pkg;

   localparam int XLEN  = 32;
   localparam int TAG_W = 6;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } funct3_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_MUL  = 3'd1,
      ST_DIV  = 3'd2,
      ST_FIX  = 3'd3,
      ST_WB   = 3'd4
   } state_e;

   function automatic logic [XLEN-1:0] magnitude(input logic is_signed,
                                                 input logic [XLEN-1:0] value);
      logic [XLEN-1:0] mag;
      if (is_signed && value[XLEN-1]) begin
         mag = {XLEN{1'b0}} - value;
      end else begin
         mag = value;
      end
      return mag;
   endfunction

   // Architectural result for divide-by-zero, or for signed overflow where the
   // quotient is the dividend itself (0x80000000) and the remainder is zero.
   function automatic logic [XLEN-1:0] div_special_result(input logic div_by_zero,
                                                          input logic is_rem,
                                                          input logic [XLEN-1:0] dividend);
      logic [XLEN-1:0] res;
      if (div_by_zero) begin
         res = is_rem ? dividend : {XLEN{1'b1}};
      end else begin
         res = is_rem ? {XLEN{1'b0}} : dividend;
      end
      return res;
   endfunction

endpackage

// File: rtl/mul_div_divider_iter.sv
// Radix-2 restoring divider on operand magnitudes. The start cycle loads the
// operands and performs the first step; done holds once all 32 bits are formed.
module mul_div_divider_iter
   import mul_div_exec_unit_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_signed,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   localparam logic [5:0] STEPS = 6'd32;

   logic [XLEN-1:0] rem_r;
   logic [XLEN-1:0] quo_r;
   logic [XLEN-1:0] dvsr_r;
   logic [5:0]      cnt_r;
   logic [XLEN-1:0] src_rem_s;
   logic [XLEN-1:0] src_quo_s;
   logic [XLEN-1:0] src_dvsr_s;
   logic [XLEN:0]   shifted_s;
   logic [XLEN:0]   diff_s;
   logic            q_bit_s;
   logic [XLEN-1:0] next_rem_s;
   logic            running_s;

   assign running_s = (cnt_r != 6'd0) && (cnt_r != STEPS);

   // One restoring step; on start it works directly on the fresh operands.
   always_comb begin
      if (start) begin
         src_rem_s  = {XLEN{1'b0}};
         src_quo_s  = magnitude(is_signed, dividend);
         src_dvsr_s = magnitude(is_signed, divisor);
      end else begin
         src_rem_s  = rem_r;
         src_quo_s  = quo_r;
         src_dvsr_s = dvsr_r;
      end
      shifted_s = {src_rem_s, src_quo_s[XLEN-1]};
      diff_s    = shifted_s - {1'b0, src_dvsr_s};
      q_bit_s   = ~diff_s[XLEN];
      if (q_bit_s) begin
         next_rem_s = diff_s[XLEN-1:0];
      end else begin
         next_rem_s = shifted_s[XLEN-1:0];
      end
   end

   // Partial remainder, quotient shift register and step counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_r  <= {XLEN{1'b0}};
         quo_r  <= {XLEN{1'b0}};
         dvsr_r <= {XLEN{1'b0}};
         cnt_r  <= 6'd0;
      end else if (start || running_s) begin
         rem_r  <= next_rem_s;
         quo_r  <= {src_quo_s[XLEN-2:0], q_bit_s};
         dvsr_r <= src_dvsr_s;
         cnt_r  <= start ? 6'd1 : (cnt_r + 6'd1);
      end else begin
         rem_r  <= rem_r;
         quo_r  <= quo_r;
         dvsr_r <= dvsr_r;
         cnt_r  <= cnt_r;
      end
   end

   assign done      = (cnt_r == STEPS);
   assign quotient  = quo_r;
   assign remainder = rem_r;

endmodule

// File: rtl/mul_div_exec_unit.sv
// RV32M multiply/divide execution unit with CDB writeback handshake.
// Define MUL_DIV_EARLY_OUT_EN to retire divide-by-zero and signed overflow straight from IDLE.
module mul_div_exec_unit
   import mul_div_exec_unit_pkg::*;
#(
   parameter int MUL_LAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             issue_valid,
   input  logic [XLEN-1:0]  op1_data,
   input  logic [XLEN-1:0]  op2_data,
   input  logic [TAG_W-1:0] rd_tag,
   input  logic             rd_tag_valid,
   input  logic [2:0]       funct3,
   output logic             ex_done,
   output logic             busy,
   output logic             cdb_req,
   input  logic             cdb_grant,
   output logic [TAG_W-1:0] cdb_tag,
   output logic [XLEN-1:0]  cdb_data
);

   state_e           state_r;
   state_e           next_state_s;
   logic [XLEN-1:0]  op1_r;
   logic [XLEN-1:0]  op2_r;
   funct3_e          funct3_r;
   logic [TAG_W-1:0] tag_r;
   logic [3:0]       cnt_r;
   logic [XLEN-1:0]  result_r;

   logic             accept_s;
   logic             early_s;
   logic             mul_last_s;
   logic             a_sign_s;
   logic             b_sign_s;
   logic [63:0]      a_ext_s;
   logic [63:0]      b_ext_s;
   logic [63:0]      product_s;
   logic [XLEN-1:0]  mul_result_s;
   logic             div_start_s;
   logic             div_done_s;
   logic [XLEN-1:0]  div_quo_s;
   logic [XLEN-1:0]  div_rem_s;
   logic             div_signed_s;
   logic             quo_neg_s;
   logic             rem_neg_s;
   logic [XLEN-1:0]  quo_fix_s;
   logic [XLEN-1:0]  rem_fix_s;
   logic [XLEN-1:0]  fix_result_s;
   logic             busy_s;
   logic             cdb_req_s;
   logic             ex_done_s;

   assign accept_s   = (state_r == ST_IDLE) && issue_valid && rd_tag_valid;
   assign mul_last_s = (cnt_r == 4'(MUL_LAT - 1));

`ifdef MUL_DIV_EARLY_OUT_EN
   assign early_s = funct3[2] &
                    ((op2_data == 32'd0) |
                     (~funct3[0] & (op1_data == 32'h8000_0000) & (op2_data == 32'hFFFF_FFFF)));
`else
   assign early_s = 1'b0;
`endif

   // 33-bit sign/zero extension, widened further so a plain 64-bit multiply is exact.
   assign a_sign_s  = op1_r[XLEN-1] & ((funct3_r == F3_MULH) | (funct3_r == F3_MULHSU));
   assign b_sign_s  = op2_r[XLEN-1] & (funct3_r == F3_MULH);
   assign a_ext_s   = {{XLEN{a_sign_s}}, op1_r};
   assign b_ext_s   = {{XLEN{b_sign_s}}, op2_r};
   assign product_s = a_ext_s * b_ext_s;

   // Select low or high product half by opcode.
   always_comb begin
      case (funct3_r)
         F3_MUL:                        mul_result_s = product_s[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU:  mul_result_s = product_s[63:XLEN];
         default:                       mul_result_s = product_s[XLEN-1:0];
      endcase
   end

   assign div_start_s = accept_s & funct3[2] & ~early_s;

   mul_div_divider_iter u_divider (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start_s),
      .is_signed (~funct3[0]),
      .dividend  (op1_data),
      .divisor   (op2_data),
      .done      (div_done_s),
      .quotient  (div_quo_s),
      .remainder (div_rem_s)
   );

   // Sign fix-up of the magnitude results; divide-by-zero bypasses the sign rules.
   always_comb begin
      div_signed_s = ~funct3_r[0];
      quo_neg_s    = div_signed_s & (op1_r[XLEN-1] ^ op2_r[XLEN-1]);
      rem_neg_s    = div_signed_s & op1_r[XLEN-1];
      quo_fix_s    = quo_neg_s ? ({XLEN{1'b0}} - div_quo_s) : div_quo_s;
      rem_fix_s    = rem_neg_s ? ({XLEN{1'b0}} - div_rem_s) : div_rem_s;
      if (op2_r == 32'd0) begin
         fix_result_s = div_special_result(1'b1, funct3_r[1], op1_r);
      end else if (funct3_r[1]) begin
         fix_result_s = rem_fix_s;
      end else begin
         fix_result_s = quo_fix_s;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and handshake outputs; ex_done follows the grant in the same cycle.
   always_comb begin
      next_state_s = state_r;
      busy_s       = (state_r != ST_IDLE);
      cdb_req_s    = 1'b0;
      ex_done_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (!funct3[2]) begin
                  next_state_s = ST_MUL;
               end else if (early_s) begin
                  next_state_s = ST_WB;
               end else begin
                  next_state_s = ST_DIV;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (mul_last_s) begin
               next_state_s = ST_WB;
            end else begin
               next_state_s = ST_MUL;
            end
         end
         ST_DIV: begin
            if (div_done_s) begin
               next_state_s = ST_FIX;
            end else begin
               next_state_s = ST_DIV;
            end
         end
         ST_FIX: next_state_s = ST_WB;
         ST_WB: begin
            cdb_req_s = 1'b1;
            if (cdb_grant) begin
               ex_done_s    = 1'b1;
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_WB;
            end
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Operand capture, multiply latency counter and result register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op1_r    <= {XLEN{1'b0}};
         op2_r    <= {XLEN{1'b0}};
         funct3_r <= F3_MUL;
         tag_r    <= {TAG_W{1'b0}};
         cnt_r    <= 4'd0;
         result_r <= {XLEN{1'b0}};
      end else if (accept_s) begin
         op1_r    <= op1_data;
         op2_r    <= op2_data;
         funct3_r <= funct3_e'(funct3);
         tag_r    <= rd_tag;
         cnt_r    <= 4'd0;
         if (early_s) begin
            result_r <= div_special_result(op2_data == 32'd0, funct3[1], op1_data);
         end else begin
            result_r <= result_r;
         end
      end else if (state_r == ST_MUL) begin
         cnt_r <= cnt_r + 4'd1;
         if (mul_last_s) begin
            result_r <= mul_result_s;
         end else begin
            result_r <= result_r;
         end
      end else if (state_r == ST_FIX) begin
         result_r <= fix_result_s;
      end else begin
         result_r <= result_r;
      end
   end

   assign busy     = busy_s;
   assign cdb_req  = cdb_req_s;
   assign ex_done  = ex_done_s;
   assign cdb_tag  = tag_r;
   assign cdb_data = result_r;

endmodule

// File: doc/mul_div_exec_unit.md
MUL_DIV_EXEC_UNIT -- requirements
Module: mul_div_exec_unit

Interface
REQ-001 Parameter MUL_LAT, default 3, SHALL set multiply cycles from issue accept to result-ready; legal range 1..8.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Port issue_valid  input  1  SHALL mean the mul/div reservation queue presents a ready entry.
REQ-005 Ports op1_data, op2_data  input  32 each  SHALL be the source operands (rs1, rs2).
REQ-006 Ports rd_tag  input  6, rd_tag_valid  input  1, funct3  input  3  SHALL be the destination token and RV32M opcode.
REQ-007 Port ex_done  output  1  SHALL pulse one cycle when the result is accepted by the CDB.
REQ-008 Port busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-009 Ports cdb_req  output  1, cdb_grant  input  1  SHALL form the CDB arbitration handshake.
REQ-010 Ports cdb_tag  output  6, cdb_data  output  32  SHALL carry the result token and value while cdb_req is high.

Function
REQ-011 States SHALL be IDLE, MUL, DIV, FIX, WB.
REQ-012 In IDLE, issue_valid=1 with rd_tag_valid=1 SHALL latch operands, tag and funct3 and move to MUL (funct3[2]=0) or DIV (funct3[2]=1); issue_valid with rd_tag_valid=0 SHALL be ignored.
REQ-013 Issue SHALL be sampled only in IDLE; the queue holds its entry until ex_done, so no re-accept occurs.
REQ-014 funct3 SHALL decode as 000 MUL(low), 001 MULH(s×s high), 010 MULHSU(s×u high), 011 MULHU(u×u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-015 MUL SHALL form a 64-bit product from 33-bit sign/zero-extended operands and count MUL_LAT cycles, then enter WB.
REQ-016 DIV SHALL run a radix-2 restoring divide on operand magnitudes, one quotient bit per cycle, 32 cycles, then FIX.
REQ-017 FIX SHALL apply signs (quotient negative iff signs differ, remainder takes dividend sign) in one cycle, then WB.
REQ-018 Divide by zero SHALL yield quotient 0xFFFFFFFF and remainder = op1 for all four divide ops.
REQ-019 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL yield DIV 0x80000000, REM 0.
REQ-020 In WB, cdb_req SHALL be high with stable cdb_tag/cdb_data until cdb_grant=1 is sampled.
REQ-021 The cycle cdb_req and cdb_grant are both high SHALL assert ex_done and return to IDLE on the next edge.
REQ-022 cdb_grant while cdb_req=0 SHALL be ignored.
REQ-023 Latency: MUL = MUL_LAT+1 cycles accept-to-cdb_req; divide = 34 cycles, excluding grant wait.

Reset
REQ-024 Reset assertion SHALL immediately force IDLE, abort any operation, and drive busy, cdb_req, ex_done low and cdb_tag, cdb_data to 0.
REQ-025 Reset SHALL clear counters and operand registers to 0; after deassertion the first possible accept is the first rising edge.

Configuration
REQ-026 Macro MUL_DIV_EARLY_OUT_EN defined SHALL route divide-by-zero and signed-overflow cases from IDLE directly to WB (cdb_req next cycle).
REQ-027 Without MUL_DIV_EARLY_OUT_EN those cases SHALL take the full 34-cycle divide path with identical results.

Structure
REQ-028 A shared package SHALL hold the funct3 encoding enum, the state enum, and the constants XLEN=32 and TAG_W=6.
REQ-029 The divider datapath SHALL be a sub-module named mul_div_divider_iter (start, signed flag, done, quotient, remainder); control and multiply stay in the top.

Verification
REQ-030 MUL 7×-3 (0x7, 0xFFFFFFFD), tag 5, grant held high -> cdb_data 0xFFFFFFEB, cdb_tag 5, cdb_req 4 cycles after accept, ex_done 1 cycle.
REQ-031 MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULH same -> 0x00000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; cdb_req 34 cycles after accept.
REQ-033 DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/-1 -> 0x80000000; with MUL_DIV_EARLY_OUT_EN cdb_req one cycle after accept, else after 34.
REQ-034 Grant withheld 10 cycles in WB -> cdb_req, tag, data stable, no ex_done; second issue_valid ignored until after ex_done.
REQ-035 Reset asserted mid-divide (cycle 12) -> busy, cdb_req drop immediately; post-reset MUL 3×4 -> 12 correct.
